// File: rtl/sub_arb_pkg.sv
// rtl/sub_arb_pkg.sv - shared widths and FSM state type for the shared-subtractor arbiter
package sub_arb_pkg;
   localparam int DATA_W     = 16;
   localparam int STAT_CNT_W = 16;
   localparam int BUSY_CNT_W = 32;

   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting the search at i_ptr
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [ID_W-1:0]  i_ptr,
   output logic [N_REQ-1:0] o_gnt,
   output logic [ID_W-1:0]  o_idx,
   output logic             o_any
);
   int j;

   // Scan from the farthest slot back to i_ptr so the nearest requester is written last and wins.
   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      j     = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         j = (int'(i_ptr) + k) % N_REQ;
         if (i_req[j]) begin
            o_gnt    = '0;
            o_gnt[j] = 1'b1;
            o_idx    = ID_W'(j);
            o_any    = 1'b1;
         end
      end
   end
endmodule

// File: rtl/sub.sv
// rtl/sub.sv - 16-bit carry-select subtractor: s = a + (~diff + 1) mod 2^16, co = carry of that add
module sub
   import sub_arb_pkg::*;
(
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_diff,
   output logic [DATA_W-1:0] o_s,
   output logic              o_co
);
   localparam int H = DATA_W / 2;

   logic [DATA_W-1:0] w_nd;
   logic [H:0]        w_lo;
   logic [H:0]        w_hi0;
   logic [H:0]        w_hi1;

   // Two's complement is formed in 16 bits first, so diff=0 wraps to 0 and gives co=0.
   assign w_nd  = ~i_diff + DATA_W'(1);
   assign w_lo  = {1'b0, i_a[H-1:0]} + {1'b0, w_nd[H-1:0]};
   assign w_hi0 = {1'b0, i_a[DATA_W-1:H]} + {1'b0, w_nd[DATA_W-1:H]};
   assign w_hi1 = w_hi0 + (H+1)'(1);

   assign o_s  = {(w_lo[H] ? w_hi1[H-1:0] : w_hi0[H-1:0]), w_lo[H-1:0]};
   assign o_co = w_lo[H] ? w_hi1[H] : w_hi0[H];
endmodule

// File: rtl/sub_share_arb.sv
// rtl/sub_share_arb.sv - round-robin sharing of one subtractor among N_REQ requesters; SUB_ARB_STATS_EN adds grant/busy counters
module sub_share_arb
   import sub_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req_valid,
   output logic [N_REQ-1:0]          req_ready,
   input  logic [N_REQ*DATA_W-1:0]   req_a,
   input  logic [N_REQ*DATA_W-1:0]   req_diff,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         rsp_s,
   output logic                      rsp_co
`ifdef SUB_ARB_STATS_EN
   ,
   input  logic                      stat_clr,
   output logic [N_REQ*STAT_CNT_W-1:0] stat_grant,
   output logic [BUSY_CNT_W-1:0]     stat_busy
`endif
);
   state_t              r_state, w_state_nxt;
   logic [ID_W-1:0]     r_rr_ptr, r_op_id, r_rsp_id;
   logic [DATA_W-1:0]   r_op_a, r_op_diff, r_rsp_s;
   logic                r_rsp_valid, r_rsp_co;
   logic [N_REQ-1:0]    w_gnt, w_req_ready;
   logic [ID_W-1:0]     w_idx;
   logic                w_any, w_accept, w_hs;
   logic [DATA_W-1:0]   w_s;
   logic                w_co;

   rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
      .i_req(req_valid), .i_ptr(r_rr_ptr), .o_gnt(w_gnt), .o_idx(w_idx), .o_any(w_any)
   );

   sub u_sub (.i_a(r_op_a), .i_diff(r_op_diff), .o_s(w_s), .o_co(w_co));

   assign w_accept = (r_state == ST_IDLE) && w_any;
   assign w_hs     = (r_state == ST_RESP) && r_rsp_valid && rsp_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_req_ready = '0;
      case (r_state)
         ST_IDLE: begin
            w_req_ready = w_gnt;
            if (w_any) w_state_nxt = ST_EXEC;
         end
         ST_EXEC: w_state_nxt = ST_RESP;
         ST_RESP: if (w_hs) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr    <= '0;
         r_op_id     <= '0;
         r_op_a      <= '0;
         r_op_diff   <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_s     <= '0;
         r_rsp_co    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op_a    <= req_a[w_idx*DATA_W +: DATA_W];
            r_op_diff <= req_diff[w_idx*DATA_W +: DATA_W];
            r_op_id   <= w_idx;
         end
         if (r_state == ST_EXEC) begin
            r_rsp_s     <= w_s;
            r_rsp_co    <= w_co;
            r_rsp_id    <= r_op_id;
            r_rsp_valid <= 1'b1;
         end
         // Pointer moves only on completion, so an abandoned or pending requester keeps its turn.
         if (w_hs) begin
            r_rsp_valid <= 1'b0;
            r_rr_ptr    <= (r_op_id == ID_W'(N_REQ - 1)) ? '0 : r_op_id + ID_W'(1);
         end
      end
   end

   assign req_ready = w_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_s     = r_rsp_s;
   assign rsp_co    = r_rsp_co;

`ifdef SUB_ARB_STATS_EN
   logic [STAT_CNT_W-1:0] r_stat_grant [N_REQ];
   logic [BUSY_CNT_W-1:0] r_stat_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_REQ; i++) r_stat_grant[i] <= '0;
         r_stat_busy <= '0;
      end else if (stat_clr) begin
         for (int i = 0; i < N_REQ; i++) r_stat_grant[i] <= '0;
         r_stat_busy <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++)
            if (w_accept && w_gnt[i] && (r_stat_grant[i] != '1))
               r_stat_grant[i] <= r_stat_grant[i] + STAT_CNT_W'(1);
         if ((r_state != ST_IDLE) && (r_stat_busy != '1))
            r_stat_busy <= r_stat_busy + BUSY_CNT_W'(1);
      end
   end

   for (genvar g = 0; g < N_REQ; g++) begin : g_stat
      assign stat_grant[g*STAT_CNT_W +: STAT_CNT_W] = r_stat_grant[g];
   end
   assign stat_busy = r_stat_busy;
`endif
endmodule

// File: tb/tb_sub_share_arb.sv
// tb/tb_sub_share_arb.sv - scoreboard bench for sub_share_arb; stat checks built when SUB_ARB_STATS_EN is defined
module tb_sub_share_arb;
   localparam int N = 4;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*16-1:0] req_a;
   logic [N*16-1:0] req_diff;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [IW-1:0]   rsp_id;
   logic [15:0]     rsp_s;
   logic            rsp_co;
`ifdef SUB_ARB_STATS_EN
   logic            stat_clr;
   logic [N*16-1:0] stat_grant;
   logic [31:0]     stat_busy;
`endif

   int checks = 0;
   int failures = 0;
   int cycle = 0;

   typedef struct {
      logic [IW-1:0] id;
      logic [15:0]   s;
      logic          co;
   } exp_t;
   exp_t exp_q[$];

   sub_share_arb #(.N_REQ(N), .ID_W(IW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_diff(req_diff), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_s(rsp_s), .rsp_co(rsp_co)
`ifdef SUB_ARB_STATS_EN
      , .stat_clr(stat_clr), .stat_grant(stat_grant), .stat_busy(stat_busy)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor: every handshake seen is scored against the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp: got id=%0d s=%0h with nothing expected", rsp_id, rsp_s);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("rsp_id", 32'(rsp_id), 32'(e.id));
            check("rsp_s", 32'(rsp_s), 32'(e.s));
            check("rsp_co", 32'(rsp_co), 32'(e.co));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int id, input logic [15:0] s, input logic co);
      exp_t e;
      e.id = IW'(id);
      e.s  = s;
      e.co = co;
      exp_q.push_back(e);
   endtask

   task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] d);
      req_a[i*16 +: 16]    = a;
      req_diff[i*16 +: 16] = d;
      req_valid[i]         = 1'b1;
   endtask

   task automatic wait_grant(input int i);
      bit seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (req_ready[i]) seen = 1;
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL grant_timeout: req %0d never granted, req_ready=%0b", i, req_ready);
      end
   endtask

   task automatic drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 40) begin
         @(negedge clk);
         k++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
      cyc();
   endtask

   task automatic do_op(input int i, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] s, input logic co);
      push(i, s, co);
      set_req(i, a, d);
      wait_grant(i);
      cyc();
      req_valid[i] = 1'b0;
      drain();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
   endtask

   int last_grant;

   initial begin
      rst_n = 1'b0;
      req_valid = '0;
      req_a = '0;
      req_diff = '0;
      rsp_ready = 1'b0;
`ifdef SUB_ARB_STATS_EN
      stat_clr = 1'b0;
`endif
      cyc();
      cyc();
      check("reset_req_ready", 32'(req_ready), 0);
      check("reset_rsp_valid", 32'(rsp_valid), 0);
      check("reset_rsp_id", 32'(rsp_id), 0);
      check("reset_rsp_s", 32'(rsp_s), 0);
      check("reset_rsp_co", 32'(rsp_co), 0);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      cyc();

      // 1: latency, grant at T and response at T+2
      push(0, 16'h0002, 1'b1);
      set_req(0, 16'd5, 16'd3);
      @(negedge clk);
      check("t1_grant_T", 32'(req_ready), 32'b0001);
      check("t1_valid_T", 32'(rsp_valid), 0);
      cyc();
      req_valid[0] = 1'b0;
      @(negedge clk);
      check("t1_valid_T1", 32'(rsp_valid), 0);
      check("t1_ready_exec", 32'(req_ready), 0);
      @(negedge clk);
      check("t1_valid_T2", 32'(rsp_valid), 1);
      drain();

      // 2: borrow and diff=0
      do_op(1, 16'd3, 16'd5, 16'hFFFE, 1'b0);
      do_op(2, 16'h1234, 16'h0000, 16'h1234, 1'b0);

      // 3: all valid, grants 0,1,2,3,0 three cycles apart
      do_reset();
      push(0, 16'h0010, 1'b0);
      push(1, 16'h000E, 1'b1);
      push(2, 16'h000C, 1'b1);
      push(3, 16'h000A, 1'b1);
      push(0, 16'h0010, 1'b0);
      for (int i = 0; i < N; i++) set_req(i, 16'(16 + i), 16'(3 * i));
      last_grant = 0;
      for (int k = 0; k < 5; k++) begin
         int idx;
         idx = k % N;
         wait_grant(idx);
         check("t3_onehot", 32'(req_ready), 32'(1 << idx));
         if (k > 0) check("t3_spacing", 32'(cycle - last_grant), 3);
         last_grant = cycle;
      end
      cyc();
      req_valid = '0;
      drain();

      // 4: response back-pressure, rr_ptr is now 1
      push(1, 16'h001B, 1'b1);
      push(3, 16'h0000, 1'b1);
      rsp_ready = 1'b0;
      set_req(1, 16'h0020, 16'h0005);
      wait_grant(1);
      cyc();
      req_valid[1] = 1'b0;
      set_req(3, 16'h0007, 16'h0007);
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("t4_hold_valid", 32'(rsp_valid), 1);
         check("t4_hold_s", 32'(rsp_s), 32'h001B);
         check("t4_hold_id", 32'(rsp_id), 1);
         check("t4_no_grant", 32'(req_ready), 0);
      end
      cyc();
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("t4_grant_after_hs", 32'(req_ready), 32'b1000);
      cyc();
      req_valid[3] = 1'b0;
      drain();

      // 5: async reset in EXEC discards the op and resets rr_ptr
      do_op(2, 16'h0100, 16'h0001, 16'h00FF, 1'b1);
      rsp_ready = 1'b0;
      set_req(2, 16'h0100, 16'h0001);
      wait_grant(2);
      cyc();
      req_valid[2] = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("t5_valid_drop", 32'(rsp_valid), 0);
      check("t5_ready_rst", 32'(req_ready), 0);
      cyc();
      cyc();
      rst_n = 1'b1;
      push(1, 16'hFFF0, 1'b0);
      push(3, 16'h0000, 1'b1);
      set_req(1, 16'h0050, 16'h0060);
      set_req(3, 16'hFFFF, 16'hFFFF);
      rsp_ready = 1'b1;
      @(negedge clk);
      check("t5_first_grant", 32'(req_ready), 32'b0010);
      cyc();
      req_valid[1] = 1'b0;
      wait_grant(3);
      cyc();
      req_valid[3] = 1'b0;
      drain();

`ifdef SUB_ARB_STATS_EN
      // 6: grant counter and clear
      stat_clr = 1'b1;
      cyc();
      stat_clr = 1'b0;
      for (int k = 0; k < 3; k++) do_op(2, 16'd9, 16'd4, 16'd5, 1'b1);
      @(negedge clk);
      check("t6_grant2", 32'(stat_grant[2*16 +: 16]), 3);
      check("t6_grant0", 32'(stat_grant[0 +: 16]), 0);
      cyc();
      stat_clr = 1'b1;
      cyc();
      stat_clr = 1'b0;
      @(negedge clk);
      check("t6_clr_grant2", 32'(stat_grant[2*16 +: 16]), 0);
      check("t6_clr_busy", stat_busy, 0);
`endif

      cyc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end
endmodule
